// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch and load/store) in front of a single-port byte RAM.
// Each access is serialised into byte cycles; mem wins ties, and results are sign/zero-extended.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  output logic                  if_done_o,
  output logic [31:0]           if_data_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_wdata_o,
  input  logic [7:0]            ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            k_q, k_d;
  logic                  id_mem_q, id_mem_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;

  logic [2:0]            n_bytes;
  logic [2:0]            addr_k;
  logic [1:0]            cap_idx;
  logic [31:0]           wshift;
  logic                  unused_addr_bits;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] w, input logic [1:0] size,
                                              input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[7:0];
    h = w[15:0];
    case (size)
      2'd0:    r = uns ? {24'd0, w[7:0]}  : 32'(b);
      2'd1:    r = uns ? {16'd0, w[15:0]} : 32'(h);
      default: r = w;
    endcase
    return r;
  endfunction

  assign unused_addr_bits = ^{if_addr_i, mem_addr_i};
  assign n_bytes = byte_count(size_q);
  assign cap_idx = k_q[1:0] - 2'd1;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    id_mem_d    = id_mem_q;
    base_d      = base_q;
    size_d      = size_q;
    we_d        = we_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_req_i || if_req_i) begin
          id_mem_d = mem_req_i;
          base_d   = mem_req_i ? mem_addr_i[ADDR_WIDTH-1:0] : if_addr_i[ADDR_WIDTH-1:0];
          size_d   = mem_req_i ? mem_size_i : 2'd2;
          we_d     = mem_req_i & mem_we_i;
          uns_d    = mem_req_i & mem_unsigned_i;
          wdata_d  = mem_req_i ? mem_wdata_i : 32'd0;
          rbuf_d   = 32'd0;
          k_d      = 3'd0;
          state_d  = XFER;
        end
      end
      XFER: begin
        if (we_q) begin
          if (k_q == n_bytes - 3'd1) state_d = DONE;
          else                       k_d = k_q + 3'd1;
        end else begin
          // RAM data lags its address by one cycle: cycle k captures byte k-1
          if (k_q != 3'd0) rbuf_d = rbuf_q | (32'(ram_rdata_i) << {cap_idx, 3'b000});
          if (k_q == n_bytes) begin
            if (id_mem_q) mem_rdata_d = extend_load(rbuf_d, size_q, uns_q);
            else          if_data_d   = rbuf_d;
            state_d = DONE;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      id_mem_q    <= 1'b0;
      base_q      <= '0;
      size_q      <= 2'd0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      id_mem_q    <= id_mem_d;
      base_q      <= base_d;
      size_q      <= size_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // RAM port is decoded from state so reset silences it immediately
  always_comb begin
    ram_addr_o  = '0;
    ram_wr_o    = 1'b0;
    ram_wdata_o = 8'd0;
    addr_k      = (k_q >= n_bytes) ? n_bytes - 3'd1 : k_q;
    wshift      = wdata_q >> {k_q[1:0], 3'b000};
    if (state_q == XFER) begin
      ram_addr_o = base_q + ADDR_WIDTH'(addr_k);
      if (we_q) begin
        ram_wr_o    = 1'b1;
        ram_wdata_o = wshift[7:0];
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign if_done_o   = (state_q == DONE) && !id_mem_q;
  assign mem_done_o  = (state_q == DONE) && id_mem_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 17, giving the width of ram_addr_o.
REQ-002 clk  in  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 if_req_i  in  1  fetch requests a 32-bit read; held until if_done_o.
REQ-005 if_addr_i  in  32  fetch byte address.
REQ-006 if_done_o  out  1  one-cycle pulse: fetch complete, if_data_o valid.
REQ-007 if_data_o  out  32  fetched word, little-endian.
REQ-008 mem_req_i  in  1  load/store request; held until mem_done_o.
REQ-009 mem_we_i  in  1  1 = store, 0 = load.
REQ-010 mem_addr_i  in  32  load/store byte address.
REQ-011 mem_size_i  in  2  0 = byte, 1 = half, 2 and 3 = word.
REQ-012 mem_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
REQ-013 mem_wdata_i  in  32  store data, with byte k in bits [8k+7:8k].
REQ-014 mem_done_o  out  1  one-cycle pulse: load/store complete.
REQ-015 mem_rdata_o  out  32  extended load result.
REQ-016 busy_o  out  1  high in every state except IDLE.
REQ-017 ram_addr_o  out  ADDR_WIDTH  byte address to the single-port byte RAM.
REQ-018 ram_wr_o  out  1  byte write strobe.
REQ-019 ram_wdata_o  out  8  write byte.
REQ-020 ram_rdata_i  in  8  read byte, valid the cycle after its address is presented.

Function
REQ-021 The states SHALL be IDLE, XFER and DONE.
REQ-022 Requests SHALL be sampled only at the rising edge that ends an IDLE cycle.
REQ-023 When both requesters are pending, the grant SHALL go to mem; otherwise it SHALL go to the single pending requester.
REQ-024 On grant, the block SHALL latch the requester id, base address, size, we, unsigned and wdata, clear byte counter k, and enter XFER.
- Later changes on the request inputs SHALL be ignored until DONE.
REQ-025 Byte count n SHALL be 1, 2 or 4 from mem_size_i; a fetch SHALL always use n = 4.
REQ-026 In XFER cycle k (k < n), ram_addr_o SHALL equal (base + k) mod 2^ADDR_WIDTH, taking the low bits of the sum.
- Carry beyond ADDR_WIDTH SHALL be discarded.
REQ-027 For a store, ram_wr_o SHALL be 1 and ram_wdata_o SHALL be latched wdata byte k in cycles k = 0..n-1; the FSM SHALL enter DONE after cycle n-1.
REQ-028 For a read, ram_wr_o SHALL be 0.
- The ram_rdata_i value present in XFER cycle k+1 SHALL be stored as byte k.
- XFER SHALL last n+1 cycles, with cycle n capture-only and ram_addr_o held at the last address.
REQ-029 Timing from grant-cycle C0 (the IDLE cycle in which the request is sampled):
- store done pulse in C(n+1);
- read done pulse in C(n+2);
- word fetch: done in C6.
REQ-030 In DONE, exactly the granted requester's done output SHALL be 1 for one cycle; the FSM SHALL then return to IDLE.
REQ-031 A requester SHALL drop or replace its request by the edge ending DONE; a request still high in IDLE SHALL be treated as new.
REQ-032 mem_rdata_o SHALL be formed as follows:
- byte load: bits [31:8] filled with bit 7, or with 0 when unsigned;
- half load: bits [31:16] filled with bit 15, or with 0 when unsigned;
- word load: unmodified.
REQ-033 if_data_o and mem_rdata_o SHALL hold their last value until overwritten by the next completion of the same requester.
REQ-034 Outside XFER, ram_wr_o SHALL be 0 and ram_addr_o and ram_wdata_o SHALL be 0.
REQ-035 Address alignment SHALL not be checked; unaligned accesses SHALL proceed byte by byte.

Reset
REQ-036 While rst_n = 0, the FSM SHALL be IDLE, and k, all latched fields and every output SHALL be 0.
REQ-037 Assertion of rst_n mid-XFER SHALL abort the transfer immediately, with no done pulse and no further ram_wr_o.
REQ-038 After release, the first grant SHALL occur at the first IDLE edge with a request.

Verification
REQ-039 Fetch: RAM[0x100..0x103] = 78 56 34 12, if_req at 0x100 -> addresses 0x100..0x103 in C1..C4, if_done_o in C6, if_data_o = 0x12345678.
REQ-040 Signed byte load: RAM[0x20] = 0x80, size 0, unsigned 0 -> mem_rdata_o = 0xFFFFFF80 with done in C3; the same load with unsigned 1 -> 0x00000080.
REQ-041 Half store: 0xAABBCCDD at 0x1FFFF, ADDR_WIDTH 17 -> writes 0xDD to 0x1FFFF (C1) and 0xCC to 0x00000 (C2), mem_done_o in C3.
REQ-042 Collision: if_req and mem_req rise in the same IDLE cycle -> mem is served first; if_req, still held, is granted in the IDLE cycle following mem's DONE.
REQ-043 Reset mid-store: rst_n low during XFER cycle 2 of a word store -> ram_wr_o = 0 at once, no done, only bytes 0..1 written.
REQ-044 Back-to-back: mem_req held through DONE with a new address -> second transfer granted in the IDLE cycle after DONE, producing exactly two done pulses.
